// File: rtl/pipe_share_arbiter_if.sv
// Handshake bundle between requesters, the arbiter and the shared external pipeline.
interface pipe_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      pipe_valid_o;
  logic [DATA_W-1:0]         pipe_data_o;
  logic [DATA_W-1:0]         pipe_data_i;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_data_o;
  logic                      rsp_last_o;
  logic                      locked_o;
  logic [ID_W-1:0]           owner_o;

  // master: requesters plus the external pipeline; slave: the arbiter
  modport master (
    output req_valid_i, req_last_i, req_data_i, pipe_data_i,
    input  req_ready_o, pipe_valid_o, pipe_data_o, rsp_valid_o, rsp_data_o,
           rsp_last_o, locked_o, owner_o
  );
  modport slave (
    input  req_valid_i, req_last_i, req_data_i, pipe_data_i,
    output req_ready_o, pipe_valid_o, pipe_data_o, rsp_valid_o, rsp_data_o,
           rsp_last_o, locked_o, owner_o
  );
endinterface

// File: rtl/pipe_share_arbiter.sv
// Frame-locking round-robin arbiter feeding one shared fixed-latency pipeline,
// with a tag delay line that routes each result back to its requester.
module pipe_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int PIPE_DEPTH = 3,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_share_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                        state;
  logic                          locked;
  logic [ID_W-1:0]               rr_ptr, owner, winner, acc_id;
  logic [ID_W:0]                 cand;
  logic                          any_vld, acc, acc_last;
  logic [DATA_W-1:0]             acc_data, pipe_data;
  logic [NUM_REQ-1:0]            ready, rsp;
  logic [PIPE_DEPTH:0]           vld_pipe, last_pipe;
  logic [PIPE_DEPTH:0][ID_W-1:0] id_pipe;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (int'(id) == NUM_REQ-1) ? '0 : id + ID_W'(1);
  endfunction

  // Walk downward so the lowest offset from rr_ptr is the last (winning) write.
  always_comb begin
    winner  = rr_ptr;
    any_vld = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (bus.req_valid_i[cand[ID_W-1:0]]) begin
        winner  = cand[ID_W-1:0];
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (!rst) begin
      if (state == LOCKED) ready[owner] = 1'b1;
      else if (any_vld)    ready[winner] = 1'b1;
    end
  end

  assign acc_id   = (state == LOCKED) ? owner : winner;
  assign acc      = |(ready & bus.req_valid_i);
  assign acc_last = bus.req_last_i[acc_id];
  assign acc_data = bus.req_data_i[int'(acc_id)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      locked    <= 1'b0;
      rr_ptr    <= '0;
      owner     <= '0;
      pipe_data <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      id_pipe   <= '0;
    end else begin
      vld_pipe[0]  <= acc;
      id_pipe[0]   <= acc_id;
      last_pipe[0] <= acc_last;
      if (acc) pipe_data <= acc_data;
      // Tag stage 0 rides with pipe_valid; stage PIPE_DEPTH lines up with pipe_data_i.
      for (int s = 1; s <= PIPE_DEPTH; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        id_pipe[s]   <= id_pipe[s-1];
        last_pipe[s] <= last_pipe[s-1];
      end
      case (state)
        IDLE: if (acc) begin
          owner <= winner;
          if (acc_last) rr_ptr <= next_id(winner);
          else begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: if (acc && acc_last) begin
          state  <= IDLE;
          locked <= 1'b0;
          rr_ptr <= next_id(owner);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Responses are suppressed while rst is high so in-flight beats never surface.
  always_comb begin
    rsp = '0;
    for (int k = 0; k < NUM_REQ; k++)
      rsp[k] = vld_pipe[PIPE_DEPTH] && !rst && (id_pipe[PIPE_DEPTH] == ID_W'(k));
  end

  assign bus.req_ready_o  = ready;
  assign bus.pipe_valid_o = vld_pipe[0];
  assign bus.pipe_data_o  = pipe_data;
  assign bus.rsp_valid_o  = rsp;
  assign bus.rsp_data_o   = bus.pipe_data_i;
  assign bus.rsp_last_o   = vld_pipe[PIPE_DEPTH] & last_pipe[PIPE_DEPTH] & ~rst;
  assign bus.locked_o     = locked;
  assign bus.owner_o      = owner;
endmodule
